// File: rtl/lzrw_hash_table_if.sv
// Handshake bundle between the hash unit, the LZRW hash table and the match comparator.
// Statistics outputs exist only when HASH_TABLE_STATS_EN is defined.
interface lzrw_hash_table_if #(
    parameter int HASH_BITS    = 12,
    parameter int POS_WIDTH    = 32,
    parameter int OFFSET_WIDTH = 12
);
    logic                    clear_req;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [HASH_BITS-1:0]    in_hash;
    logic [POS_WIDTH-1:0]    in_pos;
    logic [7:0]              in_byte;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_cand_valid;
    logic [POS_WIDTH-1:0]    out_cand_pos;
    logic [OFFSET_WIDTH-1:0] out_offset;
    logic                    out_in_window;
    logic [POS_WIDTH-1:0]    out_pos;
    logic [7:0]              out_byte;
`ifdef HASH_TABLE_STATS_EN
    logic [31:0]             stat_lookups;
    logic [31:0]             stat_hits;
`endif

    modport master (
        output clear_req, in_valid, in_hash, in_pos, in_byte, out_ready,
`ifdef HASH_TABLE_STATS_EN
        input  stat_lookups, stat_hits,
`endif
        input  busy, in_ready, out_valid, out_cand_valid, out_cand_pos,
               out_offset, out_in_window, out_pos, out_byte
    );

    modport slave (
        input  clear_req, in_valid, in_hash, in_pos, in_byte, out_ready,
`ifdef HASH_TABLE_STATS_EN
        output stat_lookups, stat_hits,
`endif
        output busy, in_ready, out_valid, out_cand_valid, out_cand_pos,
               out_offset, out_in_window, out_pos, out_byte
    );
endinterface

// File: rtl/lzrw_hash_table.sv
// LZRW pointer table: per accepted byte returns the previous position stored for its hash,
// then overwrites the entry. Optional lookup/hit counters under HASH_TABLE_STATS_EN.
module lzrw_hash_table #(
    parameter int HASH_BITS    = 12,
    parameter int POS_WIDTH    = 32,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                clock,
    input  logic                reset,
    lzrw_hash_table_if.slave    bus
);
    localparam int DEPTH = 2**HASH_BITS;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [HASH_BITS-1:0]    clr_idx_r;
    logic [HASH_BITS-1:0]    clr_idx_nxt_s;

    // Entry layout: {valid, pos}; no reset so it maps onto block RAM.
    logic [POS_WIDTH:0]      table_r [DEPTH];
    logic                    table_we_s;
    logic [HASH_BITS-1:0]    table_waddr_s;
    logic [POS_WIDTH:0]      table_wdata_s;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    consume_s;
    logic [POS_WIDTH:0]      entry_s;
    logic                    cand_valid_s;
    logic [POS_WIDTH-1:0]    cand_pos_s;
    logic [POS_WIDTH-1:0]    diff_s;
    logic                    in_window_s;
    logic [OFFSET_WIDTH-1:0] offset_s;

    logic                    out_valid_r;
    logic                    out_cand_valid_r;
    logic [POS_WIDTH-1:0]    out_cand_pos_r;
    logic [OFFSET_WIDTH-1:0] out_offset_r;
    logic                    out_in_window_r;
    logic [POS_WIDTH-1:0]    out_pos_r;
    logic [7:0]              out_byte_r;

    assign in_ready_s = reset && (state_r == ST_RUN) && !bus.clear_req
                        && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign consume_s  = out_valid_r && bus.out_ready;

    // Candidate lookup and window arithmetic on the pre-write entry value.
    always_comb begin
        entry_s      = table_r[bus.in_hash];
        cand_valid_s = entry_s[POS_WIDTH];
        if (cand_valid_s) begin
            cand_pos_s = entry_s[POS_WIDTH-1:0];
        end else begin
            cand_pos_s = '0;
        end
        diff_s = bus.in_pos - cand_pos_s;
        // diff < W exactly when every bit above the offset field is zero
        in_window_s = cand_valid_s && (diff_s != '0)
                      && (diff_s[POS_WIDTH-1:OFFSET_WIDTH] == '0);
        if (in_window_s) begin
            offset_s = diff_s[OFFSET_WIDTH-1:0];
        end else begin
            offset_s = '0;
        end
    end

    // State and sweep-index register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_idx_r <= clr_idx_nxt_s;
        end
    end

    // Next-state logic: the sweep runs to completion and ignores further clear requests.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        case (state_r)
            ST_CLEAR: begin
                clr_idx_nxt_s = clr_idx_r + HASH_BITS'(1);
                if (clr_idx_r == {HASH_BITS{1'b1}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_idx_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_idx_nxt_s = '0;
            end
        endcase
    end

    // Single write port shared by the sweep and accepted lookups (never both at once).
    always_comb begin
        table_we_s    = 1'b0;
        table_waddr_s = bus.in_hash;
        table_wdata_s = {1'b1, bus.in_pos};
        if (reset && (state_r == ST_CLEAR)) begin
            table_we_s    = 1'b1;
            table_waddr_s = clr_idx_r;
            table_wdata_s = '0;
        end else if (accept_s) begin
            table_we_s    = 1'b1;
        end else begin
            table_we_s    = 1'b0;
        end
    end

    // Table storage write.
    always_ff @(posedge clock) begin
        if (table_we_s) begin
            table_r[table_waddr_s] <= table_wdata_s;
        end
    end

    // Result register: reload on accept, drop on consume, otherwise hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_r      <= 1'b0;
            out_cand_valid_r <= 1'b0;
            out_cand_pos_r   <= '0;
            out_offset_r     <= '0;
            out_in_window_r  <= 1'b0;
            out_pos_r        <= '0;
            out_byte_r       <= 8'd0;
        end else if (accept_s) begin
            out_valid_r      <= 1'b1;
            out_cand_valid_r <= cand_valid_s;
            out_cand_pos_r   <= cand_pos_s;
            out_offset_r     <= offset_s;
            out_in_window_r  <= in_window_s;
            out_pos_r        <= bus.in_pos;
            out_byte_r       <= bus.in_byte;
        end else if (consume_s) begin
            out_valid_r      <= 1'b0;
        end
    end

    assign bus.busy           = !reset || (state_r == ST_CLEAR);
    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_r;
    assign bus.out_cand_valid = out_cand_valid_r;
    assign bus.out_cand_pos   = out_cand_pos_r;
    assign bus.out_offset     = out_offset_r;
    assign bus.out_in_window  = out_in_window_r;
    assign bus.out_pos        = out_pos_r;
    assign bus.out_byte       = out_byte_r;

`ifdef HASH_TABLE_STATS_EN
    logic        clear_entry_s;
    logic [31:0] stat_lookups_r;
    logic [31:0] stat_hits_r;

    assign clear_entry_s = (state_r == ST_RUN) && (state_nxt_s == ST_CLEAR);

    // Saturating lookup/hit counters, zeroed on reset and whenever a sweep starts.
    always_ff @(posedge clock) begin
        if (!reset || clear_entry_s) begin
            stat_lookups_r <= 32'd0;
            stat_hits_r    <= 32'd0;
        end else begin
            if (accept_s && (stat_lookups_r != 32'hFFFF_FFFF)) begin
                stat_lookups_r <= stat_lookups_r + 32'd1;
            end
            if (accept_s && in_window_s && (stat_hits_r != 32'hFFFF_FFFF)) begin
                stat_hits_r <= stat_hits_r + 32'd1;
            end
        end
    end

    assign bus.stat_lookups = stat_lookups_r;
    assign bus.stat_hits    = stat_hits_r;
`endif
endmodule

// File: doc/lzrw_hash_table.md
Name: lzrw_hash_table

Overview:
- Parametrised, handshaked successor to the compressor's pointer table.
- Sits between the hash unit and the match comparator.
- Per accepted byte: returns the last stored position for that hash with a validity flag, sliding-window offset and in-window flag, then overwrites the entry with the current position.
- Uses explicit per-entry valid bits instead of "position 0 = empty", and a RAM-friendly sweep clear.

Parameters:
- HASH_BITS, 12, table index width; DEPTH = 2**HASH_BITS (localparam).
- POS_WIDTH, 32, byte-position width.
- OFFSET_WIDTH, 12, offset width; window size W = 2**OFFSET_WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a clock edge resets.
- clear_req  in  1  one-cycle request to invalidate the whole table.
- busy  out  1  high while the clear sweep runs.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted when in_valid&&in_ready.
- in_hash  in  HASH_BITS  table index.
- in_pos  in  POS_WIDTH  current byte position.
- in_byte  in  8  literal byte, passed through.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- out_cand_valid  out  1  indexed entry held a position.
- out_cand_pos  out  POS_WIDTH  stored position (0 when !out_cand_valid).
- out_offset  out  OFFSET_WIDTH  in_pos - cand_pos when in window, else 0.
- out_in_window  out  1  candidate usable for matching.
- out_pos  out  POS_WIDTH  echoed in_pos.
- out_byte  out  8  echoed in_byte.

Behaviour:
- Storage: DEPTH entries of {valid, pos[POS_WIDTH-1:0]}, no reset on the array (RAM-inferable). Read is combinational at accept; write happens on the same edge.
- FSM states:
  - CLEAR: write {0,0} to entry clr_idx, increment clr_idx; after writing DEPTH-1, go to RUN. Takes exactly DEPTH cycles.
  - RUN: normal lookups.
- Reset: state<=CLEAR, clr_idx<=0, out_valid<=0, all out_* data <=0.
  - busy=1 and in_ready=0 during reset and for DEPTH cycles after release.
- busy = (state==CLEAR).
- in_ready = (state==RUN) && !clear_req && (!out_valid || out_ready).
- clear_req in RUN: in_ready forced low that cycle; next state CLEAR with clr_idx=0.
  - The pending output register is held and still drains normally.
  - clear_req during CLEAR is ignored; the sweep is not restarted.
- Accept (in_valid&&in_ready), on the edge:
  - entry[in_hash] <= {1,in_pos}.
  - Output registers load from the pre-write entry value; out_valid<=1.
  - Latency: one cycle from accept to out_valid.
- Arithmetic:
  - diff = (in_pos - cand_pos) mod 2**POS_WIDTH.
  - out_in_window = cand_valid && diff!=0 && diff<W.
  - out_offset = out_in_window ? diff[OFFSET_WIDTH-1:0] : 0.
  - A candidate ahead of in_pos (wrap) gives a large diff, so it is out of window.
- Output hold: while out_valid&&!out_ready, all out_* are stable and no accept occurs.
  - out_valid<=0 on consume without a simultaneous accept.
  - Consume and accept in the same cycle reloads the register, giving full throughput of 1/cycle.
- Back-to-back accepts to the same hash: the second sees the first's in_pos (write is visible next cycle).
- Reset asserted mid-operation overrides everything: pending output is dropped and the sweep restarts from 0.

Optional Feature:
- Macro HASH_TABLE_STATS_EN. When defined, adds two outputs:
  - stat_lookups (32-bit): counts accepts.
  - stat_hits (32-bit): counts accepts whose computed out_in_window=1.
  - Both saturate at 2**32-1 and clear on reset and on entry to CLEAR.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release -> busy=1, in_ready=0 for exactly 4096 cycles; then busy=0, in_ready=1.
- Accept hash 0x0A5, pos 100, then hash 0x0A5, pos 150 -> first result cand_valid=0, offset=0, in_window=0; second result cand_valid=1, cand_pos=100, offset=50, in_window=1.
- Entry pos 10, lookup pos 10+4096 -> diff=4096, in_window=0, offset=0. Lookup pos 4105 -> in_window=1, offset=4095.
- Entry pos 0xFFFFFFF0, lookup pos 0x00000005 -> diff=0x15, in_window=1, offset=21. Entry pos 0x20, lookup pos 0x10 -> in_window=0.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable. Then out_ready=1 for 3 cycles -> 3 accepts, results in order, none lost.
- Populate hash 7 with pos 33, pulse clear_req with an output pending -> pending result still delivered, busy for 4096 cycles. Next lookup on hash 7 -> cand_valid=0. Repeat with reset low mid-sweep -> sweep restarts at index 0.
